// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_OKAY = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped active transfers with a two-cycle ERROR
// and keeps a saturating count of the ERRORs it has issued.
//
// state   | meaning
// DS_OKAY | idle / zero-wait OKAY for unmapped IDLE or BUSY
// DS_ERR1 | first ERROR cycle, HREADY low, address phase ignored
// DS_ERR2 | second ERROR cycle, HREADY high, address phase re-sampled
module ahb_default_slave
  import ahb_pkg::*;
#(
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     sample,
  input  logic                     hready,
  output logic                     ds_hready,
  output logic                     ds_hresp,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  ds_state_e                state_q, state_d;
  logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;

  // State and error counter registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= DS_OKAY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and response decode.
  always_comb begin
    state_d   = state_q;
    ds_hready = 1'b1;
    ds_hresp  = HRESP_OKAY;
    unique case (state_q)
      DS_OKAY: begin
        if (hready && sample) state_d = DS_ERR1;
      end
      DS_ERR1: begin
        ds_hready = 1'b0;
        ds_hresp  = HRESP_ERROR;
        state_d   = DS_ERR2;
      end
      DS_ERR2: begin
        ds_hresp = HRESP_ERROR;
        state_d  = (hready && sample) ? DS_ERR1 : DS_OKAY;
      end
      default: state_d = DS_OKAY;
    endcase
  end

  // Count each entry into ERR1; ERR1 never loops on itself, holds at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d == DS_ERR1) && (state_q != DS_ERR1) && (cnt_q != '1))
      cnt_d = cnt_q + ERR_CNT_WIDTH'(1);
  end

  assign err_count = cnt_q;

endmodule

// File: rtl/ahb_response_mux.sv
// AHB-Lite response mux: routes the data-phase slave's ready/resp/rdata to
// the master, falling back to the internal default slave on a bad decode.
module ahb_response_mux
  import ahb_pkg::*;
#(
  parameter int NUM_SLAVES    = 2,
  parameter int DATA_WIDTH    = 64,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                             HCLK,
  input  logic                             HRESETn,
  input  logic [NUM_SLAVES-1:0]            HSEL,
  input  logic [1:0]                       HTRANS,
  input  logic [NUM_SLAVES-1:0]            HREADYOUT,
  input  logic [NUM_SLAVES-1:0]            HRESP_S,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
  output logic                             HREADY,
  output logic                             HRESP,
  output logic [DATA_WIDTH-1:0]            HRDATA,
  output logic [ERR_CNT_WIDTH-1:0]         err_count
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  logic [SEL_W-1:0]      sel_q, sel_d;
  logic                  dflt_q, dflt_d;
  logic [4:0]            hot_cnt;
  logic [SEL_W-1:0]      hsel_idx;
  logic                  unmapped;
  logic                  active;
  logic                  sample;
  logic                  slv_hready;
  logic                  slv_hresp;
  logic [DATA_WIDTH-1:0] slv_hrdata;
  logic                  ds_hready;
  logic                  ds_hresp;

  // One-hot check and index encode of the address-phase select.
  always_comb begin
    hot_cnt  = '0;
    hsel_idx = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (HSEL[i]) begin
        hot_cnt  = hot_cnt + 5'd1;
        hsel_idx = SEL_W'(i);
      end
    end
    unmapped = (hot_cnt != 5'd1);
  end

  assign active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
  assign sample = HREADY && unmapped && active;

  // Data-phase select only advances when the previous data phase completes.
  always_comb begin
    sel_d  = sel_q;
    dflt_d = dflt_q;
    if (HREADY) begin
      if (unmapped) begin
        dflt_d = 1'b1;
      end else begin
        sel_d  = hsel_idx;
        dflt_d = 1'b0;
      end
    end
  end

  // Data-phase select registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_q  <= '0;
      dflt_q <= 1'b1;
    end else begin
      sel_q  <= sel_d;
      dflt_q <= dflt_d;
    end
  end

  // Slave-side mux; compare-based so non-power-of-two counts never index out of range.
  always_comb begin
    slv_hready = 1'b1;
    slv_hresp  = HRESP_OKAY;
    slv_hrdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        slv_hready = HREADYOUT[i];
        slv_hresp  = HRESP_S[i];
        slv_hrdata = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Final selection between the addressed slave and the default slave.
  always_comb begin
    HREADY = dflt_q ? ds_hready : slv_hready;
    HRESP  = dflt_q ? ds_hresp  : slv_hresp;
    HRDATA = dflt_q ? '0        : slv_hrdata;
  end

  ahb_default_slave #(
    .ERR_CNT_WIDTH(ERR_CNT_WIDTH)
  ) u_default_slave (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .sample    (sample),
    .hready    (HREADY),
    .ds_hready (ds_hready),
    .ds_hresp  (ds_hresp),
    .err_count (err_count)
  );

endmodule

// File: tb/tb_ahb_response_mux.sv
// Directed bench for ahb_response_mux: a driver issues one cycle of inputs and
// queues the expected outputs; a monitor checks them on the falling edge.
module tb_ahb_response_mux;
  import ahb_pkg::*;

  localparam int NS = 4;
  localparam int DW = 64;
  localparam int CW = 2;

  localparam logic [DW-1:0] D0 = 64'h0A0A_0A0A_5555_0000;
  localparam logic [DW-1:0] D1 = 64'h1B1B_1B1B_6666_1111;
  localparam logic [DW-1:0] D2 = 64'hDEAD_BEEF_0123_4567;
  localparam logic [DW-1:0] D3 = 64'h3C3C_3C3C_7777_3333;

  logic              clk;
  logic              rst_n;
  logic [NS-1:0]     hsel;
  logic [1:0]        htrans;
  logic [NS-1:0]     hreadyout;
  logic [NS-1:0]     hresp_s;
  logic [NS*DW-1:0]  hrdata_s;
  logic              hready;
  logic              hresp;
  logic [DW-1:0]     hrdata;
  logic [CW-1:0]     err_count;

  typedef struct {
    logic          rdy;
    logic          rsp;
    logic [DW-1:0] dat;
    logic [CW-1:0] cnt;
    string         nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  ahb_response_mux #(
    .NUM_SLAVES(NS), .DATA_WIDTH(DW), .ERR_CNT_WIDTH(CW)
  ) dut (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel), .HTRANS(htrans),
    .HREADYOUT(hreadyout), .HRESP_S(hresp_s), .HRDATA_S(hrdata_s),
    .HREADY(hready), .HRESP(hresp), .HRDATA(hrdata), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic r, input logic p, input logic [DW-1:0] d,
                      input logic [CW-1:0] c, input string nm);
    exp_t e;
    e.rdy = r; e.rsp = p; e.dat = d; e.cnt = c; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic step(input logic r, input logic [NS-1:0] sel, input logic [1:0] tr,
                      input logic [NS-1:0] rdy, input logic [NS-1:0] rsp,
                      input logic er, input logic ep, input logic [DW-1:0] ed,
                      input logic [CW-1:0] ec, input string nm);
    @(posedge clk);
    #1;
    rst_n     = r;
    hsel      = sel;
    htrans    = tr;
    hreadyout = rdy;
    hresp_s   = rsp;
    push(er, ep, ed, ec, nm);
  endtask

  // Monitor: compare DUT outputs with the queued expectation mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (hready !== e.rdy || hresp !== e.rsp || hrdata !== e.dat || err_count !== e.cnt) begin
          errors++;
          $display("FAIL %s: got hready=%0b hresp=%0b hrdata=%h err_count=%0d, expected hready=%0b hresp=%0b hrdata=%h err_count=%0d",
                   e.nm, hready, hresp, hrdata, err_count, e.rdy, e.rsp, e.dat, e.cnt);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    hsel      = '0;
    htrans    = HTRANS_IDLE;
    hreadyout = '1;
    hresp_s   = '0;
    hrdata_s  = '0;

    // Reset with random slave-side activity.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      hsel      = NS'($urandom);
      htrans    = 2'($urandom);
      hreadyout = NS'($urandom);
      hresp_s   = NS'($urandom);
      hrdata_s  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      push(1'b1, 1'b0, '0, '0, "reset");
    end
    hrdata_s = {D3, D2, D1, D0};

    //    rst   hsel     htrans         rdyout   resp_s   rdy  rsp  data  cnt  name
    step(1'b1, 4'b0100, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1'b1, 1'b0, '0, 2'd0, "post_rst_dflt_okay");
    step(1'b1, 4'b0010, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1'b1, 1'b0, D2, 2'd0, "slave2_read");
    step(1'b1, 4'b0001, HTRANS_NONSEQ, 4'b1101, 4'b0000, 1'b0, 1'b0, D1, 2'd0, "slave1_wait1");
    step(1'b1, 4'b0001, HTRANS_NONSEQ, 4'b1101, 4'b0000, 1'b0, 1'b0, D1, 2'd0, "slave1_wait2");
    step(1'b1, 4'b0001, HTRANS_NONSEQ, 4'b1101, 4'b0000, 1'b0, 1'b0, D1, 2'd0, "slave1_wait3");
    step(1'b1, 4'b0001, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1'b1, 1'b0, D1, 2'd0, "slave1_done");
    step(1'b1, 4'b0000, HTRANS_NONSEQ, 4'b1111, 4'b0001, 1'b1, 1'b1, D0, 2'd0, "slave0_err_pass");
    step(1'b1, 4'b0100, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1'b0, 1'b1, '0, 2'd1, "dflt_err1_a");
    step(1'b1, 4'b0011, HTRANS_SEQ,    4'b1111, 4'b0000, 1'b1, 1'b1, '0, 2'd1, "dflt_err2_a");
    step(1'b1, 4'b0010, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1'b0, 1'b1, '0, 2'd2, "dflt_err1_b");
    step(1'b1, 4'b0000, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1'b1, 1'b1, '0, 2'd2, "dflt_err2_b");
    step(1'b1, 4'b0000, HTRANS_IDLE,   4'b1111, 4'b0000, 1'b0, 1'b1, '0, 2'd3, "dflt_err1_c");
    step(1'b1, 4'b0000, HTRANS_IDLE,   4'b1111, 4'b0000, 1'b1, 1'b1, '0, 2'd3, "dflt_err2_c");
    step(1'b1, 4'b0000, HTRANS_BUSY,   4'b1111, 4'b0000, 1'b1, 1'b0, '0, 2'd3, "unmapped_idle_okay");
    step(1'b1, 4'b1010, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1'b1, 1'b0, '0, 2'd3, "unmapped_busy_okay");
    step(1'b1, 4'b0000, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1'b0, 1'b1, '0, 2'd3, "sat_err1_d");
    step(1'b1, 4'b0000, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1'b1, 1'b1, '0, 2'd3, "sat_err2_d");
    step(1'b0, 4'b0000, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1'b1, 1'b0, '0, 2'd0, "rst_during_err1");
    step(1'b1, 4'b0000, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1'b1, 1'b0, '0, 2'd0, "after_rst_okay");
    step(1'b1, 4'b0001, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1'b0, 1'b1, '0, 2'd1, "restart_err1");
    step(1'b1, 4'b1000, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1'b1, 1'b1, '0, 2'd1, "restart_err2_accept");
    step(1'b1, 4'b0000, HTRANS_IDLE,   4'b1111, 4'b0000, 1'b1, 1'b0, D3, 2'd1, "slave3_no_bubble");
    step(1'b1, 4'b0000, HTRANS_IDLE,   4'b1111, 4'b0000, 1'b1, 1'b0, '0, 2'd1, "dflt_idle_okay");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
